branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter BHT_DEPTH, default 16, number of 2-bit predictor entries; power of two, 2..1024.
REQ-003 Parameter CNT_W, default 16, width of each statistics counter.
REQ-004 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 fetch_pc  input  XLEN  PC being fetched; indexes the predictor.
REQ-008 pred_taken  output  1  prediction for fetch_pc (MSB of the indexed counter).
REQ-009 ex_valid  input  1  EX-stage instruction valid.
REQ-010 ex_pc  input  XLEN  PC of the EX-stage instruction.
REQ-011 ex_branch  input  1  EX instruction is a conditional branch.
REQ-012 ex_jump  input  1  EX instruction is JAL/JALR.
REQ-013 ex_funct3  input  3  branch condition selector.
REQ-014 ex_zero, ex_lt, ex_ltu  input  1 each  ALU flags: equal, signed less-than, unsigned less-than.
REQ-015 ex_pred_taken  input  1  prediction carried down the pipe for this EX instruction.
REQ-016 PCsrc  output  1  resolved redirect: branch taken or jump.
REQ-017 mispredict  output  1  resolved direction differs from ex_pred_taken.
REQ-018 br_count, mp_count  output  CNT_W each  resolved-branch and mispredict statistics.

Function
REQ-019 Index: IDX = fetch_pc[log2(BHT_DEPTH)+1:2] for reads and ex_pc[log2(BHT_DEPTH)+1:2] for updates.
REQ-020 pred_taken SHALL be combinational from fetch_pc and the current table contents, with zero latency.
REQ-021 Condition by ex_funct3:
- 000 = ex_zero
- 001 = !ex_zero
- 100 = ex_lt
- 101 = !ex_lt
- 110 = ex_ltu
- 111 = !ex_ltu
- 010 and 011 are illegal and evaluate to not-taken.
REQ-022 br_taken = ex_valid & ex_branch & condition; PCsrc = br_taken | (ex_valid & ex_jump); PCsrc is combinational.
REQ-023 mispredict = ex_valid & (ex_branch | ex_jump) & (PCsrc != ex_pred_taken); it is combinational.
REQ-024 If ex_branch and ex_jump are both high, jump dominates: PCsrc=1 and no table update.
REQ-025 Table update happens at the rising edge when ex_valid & ex_branch & legal funct3 & !ex_jump:
- taken: counter increments, saturating at 2'b11
- not-taken: counter decrements, saturating at 2'b00.
REQ-026 Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; prediction = bit 1.
REQ-027 Simultaneous fetch read and EX update of the same index: read returns the pre-update value (no bypass); the new value is visible the next cycle.
REQ-028 Jumps, illegal funct3, and ex_valid=0 SHALL leave the table unchanged.
REQ-029 br_count increments by 1 per table update; mp_count increments by 1 per cycle with mispredict=1; both saturate at all-ones and do not wrap.
REQ-030 There is no stall or back-pressure: the unit accepts one EX resolution per cycle.

Reset
REQ-031 On rst=1 at a rising edge, every table entry SHALL become 2'b01 and br_count and mp_count SHALL become 0.
REQ-032 rst has priority over any same-cycle update; an update presented during reset is discarded.
REQ-033 During reset, pred_taken=0 (all entries 01); PCsrc and mispredict remain combinational from the EX inputs.

Verification
REQ-034 Reset, then fetch_pc=0x40 -> pred_taken=0; br_count=0; mp_count=0.
REQ-035 BEQ at ex_pc=0x40, ex_zero=1, ex_pred_taken=0, for two cycles:
- response: PCsrc=1 and mispredict=1 both cycles
- after cycle 1, entry 0 = 10 (pred_taken=1)
- after cycle 2, entry 0 = 11
- br_count=2, mp_count=2.
REQ-036 Saturation: four more taken updates at entry 0 -> entry stays 11; then one not-taken -> 10, pred_taken still 1.
REQ-037 JAL with ex_pred_taken=0 -> PCsrc=1, mispredict=1, table and br_count unchanged, mp_count+1; ex_funct3=010 branch -> PCsrc=0, no update.
REQ-038 Same-cycle read and update of index 3 (fetch_pc=0x0C, ex_pc=0x4C, BHT_DEPTH=16, taken, entry=01) -> pred_taken=0 that cycle, 1 the next; assert rst mid-sequence -> all entries 01 and counters 0 on the following cycle.
REQ-039 Counter saturation with CNT_W=4: 20 mispredicted branches -> br_count=mp_count=4'hF.

Source files
------------

// File: rtl/branch_unit.sv
// branch_unit: branch resolution, 2-bit bimodal predictor table and branch/mispredict statistics
module branch_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_zero,
  input  logic             ex_lt,
  input  logic             ex_ltu,
  input  logic             ex_pred_taken,
  output logic             PCsrc,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);
  localparam int IW = $clog2(BHT_DEPTH);
  logic [1:0]       r_bht [BHT_DEPTH];
  logic [CNT_W-1:0] r_br, r_mp;
  logic [IW-1:0]    w_ridx, w_uidx;
  logic [1:0]       w_ent, w_next;
  logic             w_legal, w_cond, w_br_taken, w_upd;
  logic             w_unused;
  assign w_ridx     = fetch_pc[IW+1:2];
  assign w_uidx     = ex_pc[IW+1:2];
  assign w_unused   = ^{fetch_pc[XLEN-1:IW+2], fetch_pc[1:0], ex_pc[XLEN-1:IW+2], ex_pc[1:0]};
  assign pred_taken = r_bht[w_ridx][1];
  assign w_legal    = ex_funct3[2:1] != 2'b01;
  assign w_cond     = w_legal & ((ex_funct3[2] ? (ex_funct3[1] ? ex_ltu : ex_lt) : ex_zero) ^ ex_funct3[0]);
  assign w_br_taken = ex_valid & ex_branch & w_cond;
  assign PCsrc      = w_br_taken | (ex_valid & ex_jump);
  assign mispredict = ex_valid & (ex_branch | ex_jump) & (PCsrc != ex_pred_taken);
  assign w_upd      = ex_valid & ex_branch & w_legal & ~ex_jump;
  assign w_ent      = r_bht[w_uidx];
  assign w_next     = w_br_taken ? ((w_ent == 2'b11) ? w_ent : w_ent + 2'd1)
                                 : ((w_ent == 2'b00) ? w_ent : w_ent - 2'd1);
  assign br_count   = r_br;
  assign mp_count   = r_mp;
  // Reset the table to weak-NT; otherwise train the resolved entry and bump saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
      r_br <= '0;
      r_mp <= '0;
    end else begin
      if (w_upd) r_bht[w_uidx] <= w_next;
      if (w_upd && !(&r_br)) r_br <= r_br + CNT_W'(1);
      if (mispredict && !(&r_mp)) r_mp <= r_mp + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed vector table plus reset and counter-saturation sequences
module tb_branch_unit;
  logic        clk = 0, rst = 1;
  logic [31:0] fetch_pc = 0, ex_pc = 0;
  logic        ex_valid = 0, ex_branch = 0, ex_jump = 0, ex_zero = 0, ex_lt = 0, ex_ltu = 0, ex_pred_taken = 0;
  logic [2:0]  ex_funct3 = 0;
  logic        pred_taken, PCsrc, mispredict, pred4, pcsrc4, mp4;
  logic [15:0] br_count, mp_count;
  logic [3:0]  br4, mpc4;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  branch_unit dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .ex_pred_taken(ex_pred_taken), .PCsrc(PCsrc), .mispredict(mispredict),
    .br_count(br_count), .mp_count(mp_count)
  );

  branch_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred4),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .ex_pred_taken(ex_pred_taken), .PCsrc(pcsrc4), .mispredict(mp4),
    .br_count(br4), .mp_count(mpc4)
  );

  typedef struct {
    logic        rst;
    logic [31:0] fpc;
    logic        v;
    logic [31:0] epc;
    logic        b, j;
    logic [2:0]  f3;
    logic        z, lt, ltu, ept;
    logic        pre, pc, mp, post;
    int          brc, mpc;
  } vec_t;

  vec_t vt [19];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int sat4(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic drive(input vec_t t);
    rst = t.rst; fetch_pc = t.fpc; ex_valid = t.v; ex_pc = t.epc; ex_branch = t.b; ex_jump = t.j;
    ex_funct3 = t.f3; ex_zero = t.z; ex_lt = t.lt; ex_ltu = t.ltu; ex_pred_taken = t.ept;
  endtask

  initial begin
    //        rst fpc    v epc    b j f3      z lt ltu ept pre pc mp post br mp
    vt[0]  = '{0, 32'h40, 1, 32'h40, 1, 0, 3'b000, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    vt[1]  = '{0, 32'h40, 1, 32'h40, 1, 0, 3'b000, 1, 0, 0, 0, 1, 1, 1, 1, 2, 2};
    vt[2]  = '{0, 32'h40, 1, 32'h40, 1, 0, 3'b000, 1, 0, 0, 1, 1, 1, 0, 1, 3, 2};
    vt[3]  = '{0, 32'h40, 1, 32'h40, 1, 0, 3'b000, 1, 0, 0, 1, 1, 1, 0, 1, 4, 2};
    vt[4]  = '{0, 32'h40, 1, 32'h40, 1, 0, 3'b000, 1, 0, 0, 1, 1, 1, 0, 1, 5, 2};
    vt[5]  = '{0, 32'h40, 1, 32'h40, 1, 0, 3'b000, 1, 0, 0, 1, 1, 1, 0, 1, 6, 2};
    vt[6]  = '{0, 32'h40, 1, 32'h40, 1, 0, 3'b000, 0, 0, 0, 1, 1, 0, 1, 1, 7, 3};
    vt[7]  = '{0, 32'h40, 1, 32'h40, 0, 1, 3'b000, 0, 0, 0, 0, 1, 1, 1, 1, 7, 4};
    vt[8]  = '{0, 32'h40, 1, 32'h40, 1, 0, 3'b010, 1, 0, 0, 0, 1, 0, 0, 1, 7, 4};
    vt[9]  = '{0, 32'h40, 1, 32'h40, 1, 1, 3'b000, 0, 0, 0, 1, 1, 1, 0, 1, 7, 4};
    vt[10] = '{0, 32'h40, 0, 32'h40, 1, 0, 3'b000, 1, 0, 0, 0, 1, 0, 0, 1, 7, 4};
    vt[11] = '{0, 32'h44, 1, 32'h44, 1, 0, 3'b001, 1, 0, 0, 0, 0, 0, 0, 0, 8, 4};
    vt[12] = '{0, 32'h48, 1, 32'h48, 1, 0, 3'b100, 0, 1, 0, 0, 0, 1, 1, 1, 9, 5};
    vt[13] = '{0, 32'h48, 1, 32'h48, 1, 0, 3'b101, 0, 1, 0, 1, 1, 0, 1, 0, 10, 6};
    vt[14] = '{0, 32'h0C, 1, 32'h4C, 1, 0, 3'b110, 0, 0, 1, 0, 0, 1, 1, 1, 11, 7};
    vt[15] = '{0, 32'h0C, 1, 32'h4C, 1, 0, 3'b111, 0, 0, 0, 1, 1, 1, 0, 1, 12, 7};
    vt[16] = '{1, 32'h40, 1, 32'h40, 1, 0, 3'b000, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
    vt[17] = '{0, 32'h0C, 0, 32'h00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[18] = '{0, 32'h40, 0, 32'h00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    fetch_pc = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    check("reset pred_taken", 32'(pred_taken), 0);
    check("reset br_count", 32'(br_count), 0);
    check("reset mp_count", 32'(mp_count), 0);
    rst = 0;

    for (int i = 0; i < 19; i++) begin
      drive(vt[i]);
      #3;
      check($sformatf("v%0d pred_pre", i), 32'(pred_taken), 32'(vt[i].pre));
      check($sformatf("v%0d PCsrc", i), 32'(PCsrc), 32'(vt[i].pc));
      check($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(vt[i].mp));
      @(posedge clk);
      #1;
      check($sformatf("v%0d pred_post", i), 32'(pred_taken), 32'(vt[i].post));
      check($sformatf("v%0d br_count", i), 32'(br_count), 32'(vt[i].brc));
      check($sformatf("v%0d mp_count", i), 32'(mp_count), 32'(vt[i].mpc));
      check($sformatf("v%0d br_count4", i), 32'(br4), 32'(sat4(vt[i].brc)));
      check($sformatf("v%0d mp_count4", i), 32'(mpc4), 32'(sat4(vt[i].mpc)));
    end

    rst = 0; fetch_pc = 32'h50; ex_valid = 1; ex_pc = 32'h50; ex_branch = 1; ex_jump = 0;
    ex_funct3 = 3'b000; ex_zero = 1; ex_lt = 0; ex_ltu = 0; ex_pred_taken = 0;
    for (int k = 1; k <= 20; k++) begin
      #3;
      check($sformatf("sat%0d mispredict", k), 32'(mispredict), 1);
      @(posedge clk);
      #1;
      check($sformatf("sat%0d br_count4", k), 32'(br4), 32'(sat4(k)));
      check($sformatf("sat%0d mp_count4", k), 32'(mpc4), 32'(sat4(k)));
    end
    ex_valid = 0;
    check("sat br_count", 32'(br_count), 20);
    check("sat mp_count", 32'(mp_count), 20);
    check("sat br_count4 final", 32'(br4), 32'hF);
    check("sat mp_count4 final", 32'(mpc4), 32'hF);
    check("sat entry strong-T", 32'(pred_taken), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
